// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Constants shared by the fetch stage and the downstream decoder:
//   FSM state encodings, default opcode length-select bit, data/instruction
//   widths, and a helper for the assembled instruction width.
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    // Default widths; the instruction is always two RAM words wide.
    localparam int DATA_W_DEF  = 8;
    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 2 * DATA_W_DEF;

    // Opcode bit that marks a 2-byte instruction.
    localparam int LEN_BIT_DEF = 7;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_OP_REQ  = 3'd1;
    localparam logic [2:0] ST_OP_CAP  = 3'd2;
    localparam logic [2:0] ST_OPR_REQ = 3'd3;
    localparam logic [2:0] ST_OPR_CAP = 3'd4;
    localparam logic [2:0] ST_OUT     = 3'd5;

    // Assembled instruction width for a given RAM data width.
    function automatic int instr_width(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage in front of a 1-cycle-latency byte RAM. Owns the PC, reads
//   the opcode byte (and operand byte for 2-byte opcodes) and presents the
//   assembled instruction to the decoder over a valid/ready handshake.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   run          fetch enable (level), sampled only when leaving IDLE/OUT
//   mem_addr     RAM read address, always the current PC
//   mem_data     RAM read data (for the address of the previous cycle)
//   redirect     load redirect_pc into PC and abandon the current fetch
//   redirect_pc  new PC value
//   instr_valid  instruction available (state OUT)
//   instr_ready  decoder accepts
//   instr        {opcode, operand}; operand is 0 for 1-byte instructions
//   instr_len    0 = 1 byte, 1 = 2 bytes
//   instr_pc     address of the opcode byte
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                LEN_BIT  = LEN_BIT_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  run,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  redirect,
    input  logic [ADDR_W-1:0]     redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [2*DATA_W-1:0]   instr,
    output logic                  instr_len,
    output logic [ADDR_W-1:0]     instr_pc
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] opc_q, opc_d;
    logic [DATA_W-1:0] opr_q, opr_d;
    logic              len_q, len_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [ADDR_W-1:0] pc_inc;

    // Natural wrap of the ADDR_W-bit adder gives modulo-2^ADDR_W PC.
    assign pc_inc = pc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        opc_d   = opc_q;
        opr_d   = opr_q;
        len_d   = len_q;
        ipc_d   = ipc_q;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_OP_REQ;
            end
            ST_OP_REQ: begin
                state_d = ST_OP_CAP;
            end
            ST_OP_CAP: begin
                opc_d = mem_data;
                ipc_d = pc_q;
                pc_d  = pc_inc;
                if (mem_data[LEN_BIT]) begin
                    len_d   = 1'b1;
                    state_d = ST_OPR_REQ;
                end else begin
                    len_d   = 1'b0;
                    opr_d   = '0;
                    state_d = ST_OUT;
                end
            end
            ST_OPR_REQ: begin
                state_d = ST_OPR_CAP;
            end
            ST_OPR_CAP: begin
                opr_d   = mem_data;
                pc_d    = pc_inc;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (instr_ready) state_d = run ? ST_OP_REQ : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Redirect wins over everything. Output registers keep their old
        // contents so a half-captured instruction never reaches instr, and
        // a same-cycle handshake in OUT has already been honoured by the
        // decoder sampling valid&ready.
        if (redirect) begin
            pc_d    = redirect_pc;
            opc_d   = opc_q;
            opr_d   = opr_q;
            len_d   = len_q;
            ipc_d   = ipc_q;
            state_d = run ? ST_OP_REQ : ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            opc_q   <= '0;
            opr_q   <= '0;
            len_q   <= 1'b0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            opc_q   <= opc_d;
            opr_q   <= opr_d;
            len_q   <= len_d;
            ipc_q   <= ipc_d;
        end
    end

    assign mem_addr    = pc_q;
    assign instr_valid = (state_q == ST_OUT);
    assign instr       = {opc_q, opr_q};
    assign instr_len   = len_q;
    assign instr_pc    = ipc_q;

endmodule
